logic_gate_arbiter: RTL

//  Shares one registered bitwise logic-gate bank (AND/OR/NOT/NAND/NOR/XOR/XNOR) between two requesters.

---
 rtl/logic_gate_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/logic_gate_arbiter.sv
// Round-robin arbiter sharing one registered bitwise gate bank between two requesters.
// Optional grant counters are enabled by defining LOGIC_GATE_ARB_STATS_EN.
module logic_gate_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [2:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic             busy
`ifdef LOGIC_GATE_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
    $error("logic_gate_arbiter: WIDTH and CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rr_ptr;
  logic             issue;
  logic             pick1;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic [WIDTH-1:0] gate_res;
  logic             gate_err;

  // The grant is decided in IDLE, registered, and IDLE is left only once the
  // registered pulse is visible, so the requester sees gnt while still in IDLE.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    pick1     = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt0 || gnt1) begin
          state_nxt = EXEC;
        end else if (req0 || req1) begin
          issue = 1'b1;
          pick1 = req1 && (!req0 || rr_ptr);
        end
      end
      EXEC: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gate_res = '0;
    gate_err = 1'b0;
    unique case (op_q)
      3'd0: gate_res = a_q & b_q;
      3'd1: gate_res = a_q | b_q;
      3'd2: gate_res = ~a_q;
      3'd3: gate_res = ~(a_q & b_q);
      3'd4: gate_res = ~(a_q | b_q);
      3'd5: gate_res = a_q ^ b_q;
      3'd6: gate_res = ~(a_q ^ b_q);
      default: gate_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt0  <= issue && !pick1;
      gnt1  <= issue && pick1;
      if (issue) rr_ptr <= ~pick1;
    end
  end

  // Operands are captured at the end of the grant cycle, from the winner only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      id_q <= 1'b0;
    end else if (state == IDLE && (gnt0 || gnt1)) begin
      op_q <= gnt1 ? op1 : op0;
      a_q  <= gnt1 ? a1 : a0;
      b_q  <= gnt1 ? b1 : b0;
      id_q <= gnt1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_data  <= gate_res;
      rsp_id    <= id_q;
      rsp_err   <= gate_err;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

`ifdef LOGIC_GATE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (issue && !pick1 && gnt_cnt0 != {CNT_W{1'b1}}) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (issue && pick1 && gnt_cnt1 != {CNT_W{1'b1}}) gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end
`endif

endmodule
